// File: rtl/alu.sv
// rtl/alu.sv - 16-bit registered ALU with logic, add/sub, compare and shift ops.
// Define ALU_IMM_EN to enable the immediate classes (imm8 = {Opcode[3:0], B[3:0]}).
module alu (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [7:0]  Opcode,
  output logic [15:0] C,
  output logic [4:0]  Flags
);

  logic [3:0]  eop;
  logic        arith;
  logic [15:0] bx;
  logic [16:0] sum;
  logic [16:0] sumc;
  logic [15:0] diff;
  logic [15:0] res;
  logic        zf, cf, of, nf, lf;

`ifdef ALU_IMM_EN
  logic [7:0] imm8;
  assign imm8 = {Opcode[3:0], B[3:0]};
`endif

  // Immediate classes are folded onto the equivalent class-0 sub-op with a substituted operand
  always_comb begin
    eop   = 4'h0;
    arith = 1'b0;
    bx    = B;
    case (Opcode[7:4])
      4'h0: begin
        eop   = Opcode[3:0];
        arith = 1'b1;
      end
`ifdef ALU_IMM_EN
      4'h5, 4'h7, 4'h9, 4'hB: begin
        eop   = Opcode[7:4];
        arith = 1'b1;
        bx    = {{8{imm8[7]}}, imm8};
      end
      4'h6: begin
        eop   = 4'h6;
        arith = 1'b1;
        bx    = {8'h00, imm8};
      end
`endif
      default: ;
    endcase
  end

  assign sum  = {1'b0, A} + {1'b0, bx};
  assign sumc = sum + 17'd1;
  assign diff = A - bx;

  always_comb begin
    res = 16'h0000;
    zf  = 1'b0;
    cf  = 1'b0;
    of  = 1'b0;
    nf  = 1'b0;
    lf  = 1'b0;
    if (arith) begin
      case (eop)
        4'h1: begin res = A & bx; zf = (res == 16'h0000); end
        4'h2: begin res = A | bx; zf = (res == 16'h0000); end
        4'h3: begin res = A ^ bx; zf = (res == 16'h0000); end
        4'h4: begin res = ~A;     zf = (res == 16'h0000); end
        4'h5: begin
          res = sum[15:0];
          zf  = (res == 16'h0000);
          of  = (A[15] == bx[15]) && (res[15] != A[15]);
        end
        4'h6: begin
          res = sum[15:0];
          zf  = (res == 16'h0000);
          cf  = sum[16];
        end
        4'h7: begin
          res = sumc[15:0];
          zf  = (res == 16'h0000);
          cf  = sumc[16];
          of  = (A[15] == bx[15]) && (res[15] != A[15]);
        end
        4'h8: begin
          res = sumc[15:0];
          zf  = (res == 16'h0000);
          cf  = sumc[16];
        end
        4'h9: begin
          res = diff;
          zf  = (res == 16'h0000);
          of  = (A[15] != bx[15]) && (res[15] != A[15]);
        end
        4'hB: begin
          zf = (A == bx);
          nf = ($signed(A) < $signed(bx));
        end
        4'hF: begin
          zf = (A == bx);
          lf = (A < bx);
        end
        default: ;
      endcase
    end else if (Opcode[7:4] == 4'h8) begin
      case (Opcode[3:0])
        4'h0, 4'h1: begin
          res = (B >= 16'd16) ? 16'h0000 : (A << B[3:0]);
          zf  = (res == 16'h0000);
        end
        4'h4: begin
          res = {A[14:0], 1'b0};
          zf  = (res == 16'h0000);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      C     <= 16'h0000;
      Flags <= 5'b00000;
    end else begin
      C     <= res;
      Flags <= {zf, cf, of, nf, lf};
    end
  end

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - directed and randomized checks of alu against an arithmetic reference model.
module tb_alu;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] A, B;
  logic [7:0]  Opcode;
  logic [15:0] C;
  logic [4:0]  Flags;

  int errors = 0;
  int checks = 0;

  alu dut (
    .clk    (clk),
    .reset_n(reset_n),
    .A      (A),
    .B      (B),
    .Opcode (Opcode),
    .C      (C),
    .Flags  (Flags)
  );

  always #5 clk = ~clk;

  // Returns {Z,Cf,O,N,L,C} computed with plain integer arithmetic
  function automatic logic [20:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [7:0] op);
    int ua, ub, sa, sb, r, k, t;
    logic z, c, o, n, l, ar;
    logic [7:0] imm;
    ua = a; sa = $signed(a); ub = b; k = op[3:0]; ar = 1'b0;
    imm = {op[3:0], b[3:0]};
    r = 0; z = 0; c = 0; o = 0; n = 0; l = 0;
    if (op[7:4] == 4'h0) ar = 1'b1;
`ifdef ALU_IMM_EN
    else if (op[7:4] == 4'h5 || op[7:4] == 4'h7 || op[7:4] == 4'h9 || op[7:4] == 4'hB) begin
      ar = 1'b1; k = op[7:4]; ub = (imm >= 128) ? int'(imm) + 65280 : int'(imm);
    end else if (op[7:4] == 4'h6) begin
      ar = 1'b1; k = 6; ub = imm;
    end
`endif
    sb = (ub >= 32768) ? ub - 65536 : ub;
    if (ar) begin
      case (k)
        1: begin r = ua & ub; z = (r == 0); end
        2: begin r = ua | ub; z = (r == 0); end
        3: begin r = ua ^ ub; z = (r == 0); end
        4: begin r = 65535 - ua; z = (r == 0); end
        5: begin t = sa + sb; r = (ua + ub) % 65536; z = (r == 0); o = (t > 32767) || (t < -32768); end
        6: begin r = (ua + ub) % 65536; z = (r == 0); c = (ua + ub) > 65535; end
        7: begin t = sa + sb + 1; r = (ua + ub + 1) % 65536; z = (r == 0);
                 c = (ua + ub + 1) > 65535; o = (t > 32767) || (t < -32768); end
        8: begin r = (ua + ub + 1) % 65536; z = (r == 0); c = (ua + ub + 1) > 65535; end
        9: begin t = sa - sb; r = (ua - ub + 65536) % 65536; z = (r == 0); o = (t > 32767) || (t < -32768); end
        11: begin z = (ua == ub); n = (sa < sb); end
        15: begin z = (ua == ub); l = (ua < ub); end
        default: ;
      endcase
    end else if (op[7:4] == 4'h8) begin
      if (op[3:0] == 4'h0 || op[3:0] == 4'h1) begin
        r = (ub >= 16) ? 0 : (ua * (1 << ub)) % 65536; z = (r == 0);
      end else if (op[3:0] == 4'h4) begin
        r = (ua * 2) % 65536; z = (r == 0);
      end
    end
    return {z, c, o, n, l, r[15:0]};
  endfunction

  task automatic check(input string tag, input logic [20:0] got, input logic [20:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed C=%h Flags=%b, expected C=%h Flags=%b",
             tag, got[15:0], got[20:16], exp[15:0], exp[20:16]);
    end
  endtask

  task automatic step(input string tag, input logic rn, input logic [15:0] a, input logic [15:0] b,
                      input logic [7:0] op, input logic [15:0] ec, input logic [4:0] ef);
    reset_n = rn; A = a; B = b; Opcode = op;
    @(posedge clk);
    #1;
    check(tag, {Flags, C}, {ef, ec});
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic [7:0]  rop;
    logic        rrn;
    logic [3:0]  cls;
    reset_n = 1'b0; A = 16'h0; B = 16'h0; Opcode = 8'h0;
    @(posedge clk);
    #1;
    check("reset", {Flags, C}, 21'h0);

    step("and",     1'b1, 16'h00F0, 16'h0F0F, 8'h01, 16'h0000, 5'b10000);
    step("or",      1'b1, 16'h00F0, 16'h0F0F, 8'h02, 16'h0FFF, 5'b00000);
    step("xor",     1'b1, 16'hFFFF, 16'h0F0F, 8'h03, 16'hF0F0, 5'b00000);
    step("not",     1'b1, 16'hFFFF, 16'h1234, 8'h04, 16'h0000, 5'b10000);
    step("add_ov",  1'b1, 16'h7FFF, 16'h0001, 8'h05, 16'h8000, 5'b00100);
    step("addu_c",  1'b1, 16'hFFFF, 16'h0001, 8'h06, 16'h0000, 5'b11000);
    step("addc",    1'b1, 16'h0003, 16'h0004, 8'h07, 16'h0008, 5'b00000);
    step("addcu_c", 1'b1, 16'hFFFF, 16'h0000, 8'h08, 16'h0000, 5'b11000);
    step("sub_z",   1'b1, 16'h0005, 16'h0005, 8'h09, 16'h0000, 5'b10000);
    step("sub_ov",  1'b1, 16'h8000, 16'h0001, 8'h09, 16'h7FFF, 5'b00100);
    step("cmp",     1'b1, 16'h0005, 16'hFFFF, 8'h0B, 16'h0000, 5'b00000);
    step("cmpu",    1'b1, 16'h0005, 16'hFFFF, 8'h0F, 16'h0000, 5'b00001);
    step("cmp_eq",  1'b1, 16'h1234, 16'h1234, 8'h0B, 16'h0000, 5'b10000);
    step("cmp_lt",  1'b1, 16'hFFFF, 16'h0005, 8'h0B, 16'h0000, 5'b00010);
    step("lshi",    1'b1, 16'h0003, 16'h0004, 8'h80, 16'h0030, 5'b00000);
    step("lsh",     1'b1, 16'h0003, 16'h0004, 8'h84, 16'h0006, 5'b00000);
    step("lshi_16", 1'b1, 16'h0003, 16'h0010, 8'h80, 16'h0000, 5'b10000);
    step("lshi_15", 1'b1, 16'h0003, 16'h000F, 8'h81, 16'h8000, 5'b00000);
    step("undef00", 1'b1, 16'h0000, 16'h0000, 8'h00, 16'h0000, 5'b00000);
    step("undef0a", 1'b1, 16'h0000, 16'h0000, 8'h0A, 16'h0000, 5'b00000);
    step("undef82", 1'b1, 16'h0001, 16'h0001, 8'h82, 16'h0000, 5'b00000);

    step("pre_rst", 1'b1, 16'h7FFF, 16'h0001, 8'h05, 16'h8000, 5'b00100);
    step("rst_mid", 1'b0, 16'h7FFF, 16'h0001, 8'h05, 16'h0000, 5'b00000);
    step("post_rst",1'b1, 16'h7FFF, 16'h0001, 8'h05, 16'h8000, 5'b00100);
`ifdef ALU_IMM_EN
    step("addi",    1'b1, 16'h0001, 16'h000F, 8'h5F, 16'h0000, 5'b10000);
    step("addui",   1'b1, 16'h0001, 16'h000F, 8'h6F, 16'h0100, 5'b00000);
`else
    step("addi_off",1'b1, 16'h0001, 16'h000F, 8'h5F, 16'h0000, 5'b00000);
    step("addui_off",1'b1,16'h0001, 16'h000F, 8'h6F, 16'h0000, 5'b00000);
`endif

    for (int i = 0; i < 400; i++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      case ($urandom_range(0, 3))
        0: cls = 4'h0;
        1: cls = 4'h8;
        2: begin
          case ($urandom_range(0, 4))
            0: cls = 4'h5;
            1: cls = 4'h6;
            2: cls = 4'h7;
            3: cls = 4'h9;
            default: cls = 4'hB;
          endcase
        end
        default: cls = 4'($urandom);
      endcase
      rop = {cls, 4'($urandom)};
      rrn = ($urandom_range(0, 15) != 0);
      reset_n = rrn; A = ra; B = rb; Opcode = rop;
      @(posedge clk);
      #1;
      check($sformatf("rand%0d op=%h a=%h b=%h rn=%b", i, rop, ra, rb, rrn),
            {Flags, C}, rrn ? model(ra, rb, rop) : 21'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
